top_pattern: RTL and testbench

TOP_PATTERN -- requirements
Module: top_pattern

---
 rtl/top_pattern_pkg.sv | 47 ++++
 rtl/pattern_trans_rom.sv | 52 +++++
 rtl/top_pattern.sv | 71 +++++++
 tb/tb_top_pattern.sv | 124 ++++++++++++
 4 files changed

// File: rtl/top_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_pattern_pkg
// Description : Constants for the three-pattern Aho-Corasick matcher: state
//               encodings, pattern strings, accept and pattern-id tables.
// Revision    : 1.0 - initial release
// ============================================================================
package top_pattern_pkg;

    localparam int STATE_W    = 4;
    localparam int NUM_STATES = 10;

    // Trie node encodings; each name spells the prefix matched so far
    localparam logic [STATE_W-1:0] c_S_ROOT = 4'd0;
    localparam logic [STATE_W-1:0] c_S_A    = 4'd1;
    localparam logic [STATE_W-1:0] c_S_AB   = 4'd2;
    localparam logic [STATE_W-1:0] c_S_ABC  = 4'd3;
    localparam logic [STATE_W-1:0] c_S_C    = 4'd4;
    localparam logic [STATE_W-1:0] c_S_CD   = 4'd5;
    localparam logic [STATE_W-1:0] c_S_CDE  = 4'd6;
    localparam logic [STATE_W-1:0] c_S_CDEF = 4'd7;
    localparam logic [STATE_W-1:0] c_S_G    = 4'd8;
    localparam logic [STATE_W-1:0] c_S_GH   = 4'd9;

    localparam logic [23:0] c_PATTERN0 = "abc";
    localparam logic [31:0] c_PATTERN1 = "cdef";
    localparam logic [15:0] c_PATTERN2 = "gh";

    localparam logic [7:0] c_CH_A = c_PATTERN0[23:16];
    localparam logic [7:0] c_CH_B = c_PATTERN0[15:8];
    localparam logic [7:0] c_CH_C = c_PATTERN0[7:0];
    localparam logic [7:0] c_CH_D = c_PATTERN1[23:16];
    localparam logic [7:0] c_CH_E = c_PATTERN1[15:8];
    localparam logic [7:0] c_CH_F = c_PATTERN1[7:0];
    localparam logic [7:0] c_CH_G = c_PATTERN2[15:8];
    localparam logic [7:0] c_CH_H = c_PATTERN2[7:0];

    // Bit i set when state i completes a pattern (states 3, 7, 9)
    localparam logic [NUM_STATES-1:0] c_ACCEPT_TABLE = 10'b10_1000_1000;

    // Entry i is the pattern index completed in state i (0 for non-accepting)
    localparam logic [NUM_STATES-1:0][1:0] c_PATTERN_ID_TABLE = {
        2'd2, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0
    };

endpackage : top_pattern_pkg
`default_nettype wire

// File: rtl/pattern_trans_rom.sv
`default_nettype none
// ============================================================================
// Module      : pattern_trans_rom
// Description : Combinational delta(state, ch) table for the matcher, with
//               the fail links already folded into each entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_trans_rom
    import top_pattern_pkg::*;
#(
    parameter int STATE_W = top_pattern_pkg::STATE_W
) (
    input  logic [STATE_W-1:0] i_state,
    input  logic [7:0]         i_ch,
    output logic [STATE_W-1:0] o_next_state
);

    logic                w_in_range;
    logic [STATE_W-1:0]  w_next_state;

    assign w_in_range = (i_state < STATE_W'(NUM_STATES));

    // 'a' and 'g' restart their pattern from any state, 'c' from anywhere
    // except "ab", and 'd' also follows "abc" through its fail link to "c".
    always_comb begin
        w_next_state = STATE_W'(c_S_ROOT);
        if (w_in_range) begin
            case (i_ch)
                c_CH_A: w_next_state = STATE_W'(c_S_A);
                c_CH_B: if (i_state == STATE_W'(c_S_A))
                            w_next_state = STATE_W'(c_S_AB);
                c_CH_C: w_next_state = (i_state == STATE_W'(c_S_AB)) ?
                                       STATE_W'(c_S_ABC) : STATE_W'(c_S_C);
                c_CH_D: if (i_state == STATE_W'(c_S_C) ||
                            i_state == STATE_W'(c_S_ABC))
                            w_next_state = STATE_W'(c_S_CD);
                c_CH_E: if (i_state == STATE_W'(c_S_CD))
                            w_next_state = STATE_W'(c_S_CDE);
                c_CH_F: if (i_state == STATE_W'(c_S_CDE))
                            w_next_state = STATE_W'(c_S_CDEF);
                c_CH_G: w_next_state = STATE_W'(c_S_G);
                c_CH_H: if (i_state == STATE_W'(c_S_G))
                            w_next_state = STATE_W'(c_S_GH);
                default: w_next_state = STATE_W'(c_S_ROOT);
            endcase
        end
    end

    assign o_next_state = w_next_state;

endmodule : pattern_trans_rom
`default_nettype wire

// File: rtl/top_pattern.sv
`default_nettype none
// ============================================================================
// Module      : top_pattern
// Description : Streaming matcher for "abc", "cdef", "gh", one char per clock.
//               Define TOP_PATTERN_MATCH_ID_EN to add the match_id output.
// Revision    : 1.0 - initial release
// ============================================================================
module top_pattern
    import top_pattern_pkg::*;
#(
    parameter int STATE_W = top_pattern_pkg::STATE_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] input_ch,
    output logic       ifFinal
`ifdef TOP_PATTERN_MATCH_ID_EN
    ,
    output logic [1:0] match_id
`endif
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               w_accept;

    pattern_trans_rom #(
        .STATE_W      (STATE_W)
    ) u_trans_rom (
        .i_state      (r_state),
        .i_ch         (input_ch),
        .o_next_state (w_next_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STATE_W'(c_S_ROOT);
        end else begin
            r_state <= w_next_state;
        end
    end

    // Unused encodings never match a table entry and decode as non-accepting
    always_comb begin
        w_accept = 1'b0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (r_state == STATE_W'(i)) begin
                w_accept = c_ACCEPT_TABLE[i];
            end
        end
    end

    assign ifFinal = w_accept;

`ifdef TOP_PATTERN_MATCH_ID_EN
    logic [1:0] w_pattern_id;

    always_comb begin
        w_pattern_id = 2'd0;
        for (int i = 0; i < NUM_STATES; i++) begin
            if (r_state == STATE_W'(i)) begin
                w_pattern_id = c_PATTERN_ID_TABLE[i];
            end
        end
    end

    assign match_id = w_accept ? w_pattern_id : 2'd0;
`endif

endmodule : top_pattern
`default_nettype wire

// File: tb/tb_top_pattern.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_pattern
// Description : Self-checking bench for top_pattern; the reference model keeps
//               the recent character history and tests for pattern suffixes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_pattern;

    logic       clk;
    logic       reset;
    logic [7:0] input_ch;
    logic       ifFinal;
`ifdef TOP_PATTERN_MATCH_ID_EN
    logic [1:0] match_id;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] hist[$];

    top_pattern dut (
        .clk      (clk),
        .reset    (reset),
        .input_ch (input_ch),
`ifdef TOP_PATTERN_MATCH_ID_EN
        .match_id (match_id),
`endif
        .ifFinal  (ifFinal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit ends_with(input string p);
        int n;
        n = p.len();
        if (hist.size() < n) return 1'b0;
        for (int i = 0; i < n; i++) begin
            if (hist[hist.size() - n + i] != p[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Apply one character (or a reset edge), then compare against the model
    task automatic step(input logic [7:0] ch, input logic rst, input string tag);
        bit         exp_final;
        logic [1:0] exp_id;
        reset    = rst;
        input_ch = ch;
        @(posedge clk);
        #1;
        if (rst) begin
            hist.delete();
        end else begin
            hist.push_back(ch);
            if (hist.size() > 4) void'(hist.pop_front());
        end
        exp_final = ends_with("abc") || ends_with("cdef") || ends_with("gh");
        exp_id    = ends_with("cdef") ? 2'd1 : ends_with("gh") ? 2'd2 : 2'd0;
        check(tag, {31'd0, ifFinal}, {31'd0, exp_final});
`ifdef TOP_PATTERN_MATCH_ID_EN
        check({tag, "_id"}, {30'd0, match_id}, {30'd0, exp_id});
`else
        if (exp_id != 2'd0) hist = hist;
`endif
    endtask

    task automatic feed(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1'b0, tag);
        end
    endtask

    initial begin
        logic [7:0] alpha;
        reset    = 1'b1;
        input_ch = 8'h61;
        alpha    = 8'h00;

        // Reset held with 'a' on the input
        for (int i = 0; i < 4; i++) step(8'h61, 1'b1, "reset_hold");

        feed("abcdefgh", "seq_a_to_h");
        step(8'h00, 1'b1, "reset_mid");
        feed("abd", "abd_nomatch");
        feed("cdef", "cdef_after_abd");
        feed("ab", "partial_ab");
        step(8'h63, 1'b1, "reset_during_ab");
        feed("c", "c_after_reset");
        feed("gggh", "gggh");
        feed("xyz", "xyz_to_root");
        feed("abcdef", "overlap_abcdef");
        feed("abcgh", "back_to_back");
        step(8'hFF, 1'b0, "byte_ff");
        step(8'h00, 1'b0, "byte_00");

        // Randomized stream biased toward pattern characters
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0:       alpha = 8'($urandom_range(0, 255));
                1:       alpha = 8'h78;
                default: alpha = 8'h61 + 8'($urandom_range(0, 7));
            endcase
            step(alpha, ($urandom_range(0, 39) == 0), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_top_pattern
`default_nettype wire
